// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: sequences the external pc register, runs the instruction
// memory fetch handshake and hands fetched words to decode.
// Optional fetch timeout is enabled by defining PC_FETCH_CTRL_TIMEOUT_EN.
//
// Handshakes: IMEM_REQ stays high with IMEM_ADDR = PC_IN until a cycle with
// IMEM_ACK high. INSTR_VALID stays high with INSTR/INSTR_PC stable until either
// a cycle with INSTR_READY high (transfer) or a redirect arrives (word dropped).
module pc_fetch_ctrl #(
`ifdef PC_FETCH_CTRL_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES = 16,
`endif
    parameter logic [31:0] TRAP_VECTOR    = 32'h1A000080
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] PC_IN,
    output logic        PC_RES,
    output logic        PC_EN,
    output logic        PC_MODE,
    output logic [31:0] PC_D,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] INSTR,
    output logic [31:0] INSTR_PC,
    input  logic        JUMP_REQ,
    input  logic [31:0] JUMP_TGT,
    input  logic        TRAP_REQ,
    output logic        FETCH_ERR
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        pc_res_q, pc_res_d;
    logic        pc_en_q, pc_en_d;
    logic        pc_mode_q, pc_mode_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        fetch_err_q, fetch_err_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_trap_q, pend_trap_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        mrg_vld, mrg_trap;
    logic [31:0] mrg_tgt, load_val;
    logic        timeout;

`ifdef PC_FETCH_CTRL_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] to_cnt_q, to_cnt_d;

    // Count FETCH cycles without acknowledge; the count rests at zero outside FETCH.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_FETCH && !IMEM_ACK) begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
    end

    assign timeout = (state_q == ST_FETCH) && !IMEM_ACK && (to_cnt_d == TO_LIMIT);

    // Timeout counter register.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) to_cnt_q <= '0;
        else      to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Merge the pending redirect with this cycle's requests: trap beats jump,
    // a jump never replaces a pending trap. Jump targets are word aligned.
    always_comb begin
        mrg_vld  = pend_vld_q;
        mrg_trap = pend_trap_q;
        mrg_tgt  = pend_tgt_q;
        if (TRAP_REQ) begin
            mrg_vld  = 1'b1;
            mrg_trap = 1'b1;
        end else if (JUMP_REQ && !(pend_vld_q && pend_trap_q)) begin
            mrg_vld  = 1'b1;
            mrg_trap = 1'b0;
            mrg_tgt  = JUMP_TGT & 32'hFFFF_FFFC;
        end
        load_val = mrg_trap ? TRAP_VECTOR : mrg_tgt;
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d       = state_q;
        pc_res_d      = 1'b0;
        pc_en_d       = 1'b0;
        pc_mode_d     = 1'b0;
        pc_d_d        = pc_d_q;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_err_d   = 1'b0;
        pend_vld_d    = pend_vld_q;
        pend_trap_d   = pend_trap_q;
        pend_tgt_d    = pend_tgt_q;
        case (state_q)
            ST_INIT: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                if (timeout) begin
                    state_d     = ST_UPDATE;
                    pc_en_d     = 1'b1;
                    pc_mode_d   = 1'b1;
                    pc_d_d      = TRAP_VECTOR;
                    fetch_err_d = 1'b1;
                    pend_vld_d  = 1'b0;
                    pend_trap_d = 1'b0;
                end else if (IMEM_ACK) begin
                    instr_d    = IMEM_RDATA;
                    instr_pc_d = PC_IN;
                    if (mrg_vld) begin
                        state_d     = ST_UPDATE;
                        pc_en_d     = 1'b1;
                        pc_mode_d   = 1'b1;
                        pc_d_d      = load_val;
                        pend_vld_d  = 1'b0;
                        pend_trap_d = 1'b0;
                    end else begin
                        state_d       = ST_ISSUE;
                        instr_valid_d = 1'b1;
                    end
                end else begin
                    imem_req_d  = 1'b1;
                    pend_vld_d  = mrg_vld;
                    pend_trap_d = mrg_trap;
                    pend_tgt_d  = mrg_tgt;
                end
            end
            ST_ISSUE: begin
                if (mrg_vld) begin
                    state_d     = ST_UPDATE;
                    pc_en_d     = 1'b1;
                    pc_mode_d   = 1'b1;
                    pc_d_d      = load_val;
                    pend_vld_d  = 1'b0;
                    pend_trap_d = 1'b0;
                end else if (INSTR_READY) begin
                    state_d = ST_UPDATE;
                    pc_en_d = 1'b1;
                end else begin
                    instr_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_FETCH;
                imem_req_d  = 1'b1;
                pend_vld_d  = mrg_vld;
                pend_trap_d = mrg_trap;
                pend_tgt_d  = mrg_tgt;
            end
        endcase
    end

    // State, output and pending-redirect registers.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q       <= ST_INIT;
            pc_res_q      <= 1'b1;
            pc_en_q       <= 1'b0;
            pc_mode_q     <= 1'b0;
            pc_d_q        <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fetch_err_q   <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_trap_q   <= 1'b0;
            pend_tgt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_res_q      <= pc_res_d;
            pc_en_q       <= pc_en_d;
            pc_mode_q     <= pc_mode_d;
            pc_d_q        <= pc_d_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_err_q   <= fetch_err_d;
            pend_vld_q    <= pend_vld_d;
            pend_trap_q   <= pend_trap_d;
            pend_tgt_q    <= pend_tgt_d;
        end
    end

    assign PC_RES      = pc_res_q;
    assign PC_EN       = pc_en_q;
    assign PC_MODE     = pc_mode_q;
    assign PC_D        = pc_d_q;
    assign IMEM_REQ    = imem_req_q;
    assign IMEM_ADDR   = PC_IN;
    assign INSTR_VALID = instr_valid_q;
    assign INSTR       = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign FETCH_ERR   = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: models the pc register and an instruction memory
// with programmable acknowledge latency; issued instructions are scoreboarded.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] PC_RST = 32'h1A000000;
    localparam logic [31:0] TRAPV  = 32'h1A000080;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] PC_IN;
    logic        PC_RES, PC_EN, PC_MODE;
    logic [31:0] PC_D;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTR, INSTR_PC;
    logic        JUMP_REQ;
    logic [31:0] JUMP_TGT;
    logic        TRAP_REQ;
    logic        FETCH_ERR;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] sb_item;

    int ack_delay = 0;
    logic ack_force = 1'b0;
    int req_age;
    logic [31:0] pc_model;

    // Clock.
    always #5 CLK = ~CLK;

    pc_fetch_ctrl dut (
        .CLK(CLK), .RES(RES), .PC_IN(PC_IN), .PC_RES(PC_RES), .PC_EN(PC_EN),
        .PC_MODE(PC_MODE), .PC_D(PC_D), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
        .JUMP_REQ(JUMP_REQ), .JUMP_TGT(JUMP_TGT), .TRAP_REQ(TRAP_REQ),
        .FETCH_ERR(FETCH_ERR)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // pc register model: synchronous reset, +4 or load.
    always @(posedge CLK) begin
        if (PC_RES)     pc_model <= PC_RST;
        else if (PC_EN) pc_model <= PC_MODE ? PC_D : pc_model + 32'd4;
    end
    assign PC_IN = pc_model;

    // Memory model: acknowledge once the request has waited ack_delay cycles.
    always @(posedge CLK) begin
        if (!RES || !IMEM_REQ || IMEM_ACK) req_age <= 0;
        else                               req_age <= req_age + 1;
    end
    assign IMEM_ACK   = ack_force || (IMEM_REQ && (req_age >= ack_delay));
    assign IMEM_RDATA = mem_word(IMEM_ADDR);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard: every accepted instruction must match the oldest expected one.
    always @(negedge CLK) begin
        if (RES === 1'b1 && INSTR_VALID && INSTR_READY && !JUMP_REQ && !TRAP_REQ) begin
            check_eq("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                sb_item = exp_q.pop_front();
                check_eq("sb_instr", INSTR, sb_item[31:0]);
                check_eq("sb_instr_pc", INSTR_PC, sb_item[63:32]);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!INSTR_VALID && n < budget) begin
            tick();
            n++;
        end
        check_eq("valid_seen", 32'(INSTR_VALID), 32'd1);
    endtask

    // Entered in a FETCH cycle for address a; leaves in the following UPDATE cycle.
    task automatic seq_fetch(input logic [31:0] a);
        check_eq("fetch_req", 32'(IMEM_REQ), 32'd1);
        check_eq("fetch_addr", IMEM_ADDR, a);
        exp_q.push_back({a, mem_word(a)});
        wait_valid(40);
        check_eq("issue_instr", INSTR, mem_word(a));
        check_eq("issue_instr_pc", INSTR_PC, a);
        INSTR_READY = 1'b1;
        tick();
        INSTR_READY = 1'b0;
        check_eq("inc_pc_en", 32'(PC_EN), 32'd1);
        check_eq("inc_pc_mode", 32'(PC_MODE), 32'd0);
        check_eq("inc_valid_low", 32'(INSTR_VALID), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RES = 1'b0;
        INSTR_READY = 1'b0;
        JUMP_REQ = 1'b0;
        JUMP_TGT = '0;
        TRAP_REQ = 1'b0;
        repeat (3) tick();

        // Reset values.
        check_eq("rst_pc_res", 32'(PC_RES), 32'd1);
        check_eq("rst_pc_en", 32'(PC_EN), 32'd0);
        check_eq("rst_pc_mode", 32'(PC_MODE), 32'd0);
        check_eq("rst_pc_d", PC_D, 32'd0);
        check_eq("rst_req", 32'(IMEM_REQ), 32'd0);
        check_eq("rst_valid", 32'(INSTR_VALID), 32'd0);
        check_eq("rst_instr", INSTR, 32'd0);
        check_eq("rst_instr_pc", INSTR_PC, 32'd0);
        check_eq("rst_fetch_err", 32'(FETCH_ERR), 32'd0);

        // Release: one PC_RES cycle, then fetch from the reset vector.
        RES = 1'b1;
        check_eq("init_pc_res", 32'(PC_RES), 32'd1);
        tick();
        check_eq("init_pc_res_drop", 32'(PC_RES), 32'd0);
        seq_fetch(PC_RST);
        tick();

        // Decode stalls for 5 cycles.
        check_eq("stall_fetch_addr", IMEM_ADDR, PC_RST + 32'd4);
        exp_q.push_back({PC_RST + 32'd4, mem_word(PC_RST + 32'd4)});
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(INSTR_VALID), 32'd1);
            check_eq("stall_instr", INSTR, mem_word(PC_RST + 32'd4));
            check_eq("stall_instr_pc", INSTR_PC, PC_RST + 32'd4);
            check_eq("stall_pc_en", 32'(PC_EN), 32'd0);
            tick();
        end
        INSTR_READY = 1'b1;
        tick();
        INSTR_READY = 1'b0;
        check_eq("stall_inc_en", 32'(PC_EN), 32'd1);
        check_eq("stall_inc_mode", 32'(PC_MODE), 32'd0);
        tick();

        // Jump during ISSUE wins over READY; target is word aligned.
        check_eq("j_issue_fetch_addr", IMEM_ADDR, PC_RST + 32'd8);
        tick();
        check_eq("j_issue_valid", 32'(INSTR_VALID), 32'd1);
        JUMP_REQ = 1'b1;
        JUMP_TGT = 32'h1A000123;
        INSTR_READY = 1'b1;
        tick();
        JUMP_REQ = 1'b0;
        INSTR_READY = 1'b0;
        check_eq("j_issue_pc_en", 32'(PC_EN), 32'd1);
        check_eq("j_issue_pc_mode", 32'(PC_MODE), 32'd1);
        check_eq("j_issue_pc_d", PC_D, 32'h1A000120);
        check_eq("j_issue_valid_drop", 32'(INSTR_VALID), 32'd0);
        tick();
        seq_fetch(32'h1A000120);

        // Jump then trap while a fetch waits 3 cycles: word discarded, trap wins.
        ack_delay = 3;
        tick();
        check_eq("jt_fetch_addr", IMEM_ADDR, 32'h1A000124);
        JUMP_REQ = 1'b1;
        JUMP_TGT = 32'h1A000200;
        tick();
        JUMP_REQ = 1'b0;
        TRAP_REQ = 1'b1;
        check_eq("jt_wait_req", 32'(IMEM_REQ), 32'd1);
        tick();
        TRAP_REQ = 1'b0;
        check_eq("jt_wait_valid", 32'(INSTR_VALID), 32'd0);
        tick();
        check_eq("jt_ack_cycle_req", 32'(IMEM_REQ), 32'd1);
        tick();
        check_eq("jt_pc_en", 32'(PC_EN), 32'd1);
        check_eq("jt_pc_mode", 32'(PC_MODE), 32'd1);
        check_eq("jt_pc_d", PC_D, TRAPV);
        check_eq("jt_valid", 32'(INSTR_VALID), 32'd0);
        ack_delay = 0;
        tick();
        seq_fetch(TRAPV);

        // Trap then jump while fetching: the later jump does not replace the trap.
        ack_delay = 2;
        tick();
        check_eq("tj_fetch_addr", IMEM_ADDR, TRAPV + 32'd4);
        TRAP_REQ = 1'b1;
        tick();
        TRAP_REQ = 1'b0;
        JUMP_REQ = 1'b1;
        JUMP_TGT = 32'h1A000300;
        tick();
        JUMP_REQ = 1'b0;
        tick();
        check_eq("tj_pc_mode", 32'(PC_MODE), 32'd1);
        check_eq("tj_pc_d", PC_D, TRAPV);
        check_eq("tj_valid", 32'(INSTR_VALID), 32'd0);
        ack_delay = 0;
        tick();

        // Trap and jump in the same ISSUE cycle: trap wins.
        check_eq("tsame_fetch_addr", IMEM_ADDR, TRAPV);
        tick();
        check_eq("tsame_valid", 32'(INSTR_VALID), 32'd1);
        TRAP_REQ = 1'b1;
        JUMP_REQ = 1'b1;
        JUMP_TGT = 32'h1A000400;
        tick();
        TRAP_REQ = 1'b0;
        JUMP_REQ = 1'b0;
        check_eq("tsame_pc_mode", 32'(PC_MODE), 32'd1);
        check_eq("tsame_pc_d", PC_D, TRAPV);
        tick();
        seq_fetch(TRAPV);

        // Jump during UPDATE is pending; a later jump overwrites it; the next word is discarded.
        JUMP_REQ = 1'b1;
        JUMP_TGT = 32'h1A000505;
        ack_delay = 1;
        tick();
        check_eq("jupd_fetch_addr", IMEM_ADDR, TRAPV + 32'd4);
        JUMP_TGT = 32'h1A000604;
        tick();
        JUMP_REQ = 1'b0;
        tick();
        check_eq("jupd_pc_en", 32'(PC_EN), 32'd1);
        check_eq("jupd_pc_mode", 32'(PC_MODE), 32'd1);
        check_eq("jupd_pc_d", PC_D, 32'h1A000604);
        check_eq("jupd_valid", 32'(INSTR_VALID), 32'd0);

        // Reset while a request is outstanding; a late acknowledge is ignored.
        ack_delay = 100;
        tick();
        check_eq("rmid_fetch_addr", IMEM_ADDR, 32'h1A000604);
        tick();
        check_eq("rmid_req_held", 32'(IMEM_REQ), 32'd1);
        RES = 1'b0;
        #1;
        check_eq("rmid_req", 32'(IMEM_REQ), 32'd0);
        check_eq("rmid_pc_res", 32'(PC_RES), 32'd1);
        check_eq("rmid_pc_en", 32'(PC_EN), 32'd0);
        check_eq("rmid_pc_d", PC_D, 32'd0);
        check_eq("rmid_valid", 32'(INSTR_VALID), 32'd0);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        check_eq("rmid_late_valid", 32'(INSTR_VALID), 32'd0);
        check_eq("rmid_late_instr", INSTR, 32'd0);
        tick();
        RES = 1'b1;
        ack_delay = 0;
        check_eq("rmid_init_pc_res", 32'(PC_RES), 32'd1);
        tick();
        check_eq("rmid_pc_res_drop", 32'(PC_RES), 32'd0);
        seq_fetch(PC_RST);

        // No acknowledge for a long time.
        ack_delay = 100;
        tick();
`ifdef PC_FETCH_CTRL_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            check_eq("to_wait_err", 32'(FETCH_ERR), 32'd0);
            check_eq("to_wait_req", 32'(IMEM_REQ), 32'd1);
            tick();
        end
        check_eq("to_fetch_err", 32'(FETCH_ERR), 32'd1);
        check_eq("to_req_drop", 32'(IMEM_REQ), 32'd0);
        check_eq("to_pc_en", 32'(PC_EN), 32'd1);
        check_eq("to_pc_mode", 32'(PC_MODE), 32'd1);
        check_eq("to_pc_d", PC_D, TRAPV);
        ack_delay = 0;
        tick();
        check_eq("to_err_pulse", 32'(FETCH_ERR), 32'd0);
        seq_fetch(TRAPV);
`else
        for (int i = 0; i < 20; i++) begin
            check_eq("nto_err", 32'(FETCH_ERR), 32'd0);
            check_eq("nto_req", 32'(IMEM_REQ), 32'd1);
            tick();
        end
        ack_delay = 0;
        seq_fetch(PC_RST + 32'd4);
`endif

        tick();
        tick();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
